// File: rtl/ram8_pkg.sv
// Shared types and constants for the ram8 sequencer slice.
// Optional write-verify build: define RAM8_SEQ_WR_VERIFY_EN.
package ram8_pkg;

  localparam int DW = 16;
  localparam int AW = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    WR_BEAT,
    RD_ACC,
    RD_HOLD,
    VERIFY
  } state_e;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
  } cmd_t;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return a + AW'(1);
  endfunction

endpackage

// File: rtl/ram8_addr_ctr.sv
// Loadable wrapping address counter plus remaining-beat counter for one burst.
module ram8_addr_ctr
  import ram8_pkg::*;
#(
  parameter int W = AW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_addr,
  input  logic [W-1:0] load_len,
  output logic [W-1:0] cur_addr,
  output logic [W-1:0] nxt_addr,
  output logic         last
);

  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] rem_q, rem_d;

  // Address wraps naturally at the counter width, so long bursts roll over to 0.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = load_addr;
      rem_d  = load_len;
    end else if (inc) begin
      addr_d = addr_q + W'(1);
      rem_d  = rem_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign cur_addr = addr_q;
  assign nxt_addr = addr_d;
  assign last     = (rem_q == '0);

endmodule

// File: rtl/ram8_seq_master.sv
// Burst sequencer driving an 8x16 register-file RAM, one RAM access per beat.
// Define RAM8_SEQ_WR_VERIFY_EN to read back each written word and flag mismatches on wr_err.
module ram8_seq_master
  import ram8_pkg::*;
#(
  parameter int DW = ram8_pkg::DW,
  parameter int AW = ram8_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          mem_r,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d,
`ifdef RAM8_SEQ_WR_VERIFY_EN
  output logic          wr_err,
`endif
  input  logic [DW-1:0] mem_q
);

  state_e        state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          mem_r_q, mem_r_d;
  logic          mem_w_q, mem_w_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_d_q, mem_d_d;
`ifdef RAM8_SEQ_WR_VERIFY_EN
  logic          wr_err_q, wr_err_d;
`endif

  logic          ctr_load, ctr_inc;
  logic [AW-1:0] cur_addr, nxt_addr;
  logic          last;
  cmd_t          cmd_in;
  logic          cmd_fire;

  assign cmd_in   = '{write: cmd_write, addr: cmd_addr, len: cmd_len};
  assign cmd_fire = cmd_valid && cmd_ready_q;

  ram8_addr_ctr #(.W(AW)) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (ctr_load),
    .inc       (ctr_inc),
    .load_addr (cmd_in.addr),
    .load_len  (cmd_in.len),
    .cur_addr  (cur_addr),
    .nxt_addr  (nxt_addr),
    .last      (last)
  );

  // Strobes are registered on entry to the access state, so the address they
  // carry is the counter's next value rather than its current one.
  always_comb begin
    state_d    = state_q;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    mem_r_d    = 1'b0;
    mem_w_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
`ifdef RAM8_SEQ_WR_VERIFY_EN
    wr_err_d   = wr_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          ctr_load = 1'b1;
          if (cmd_in.write) begin
            state_d = WR_ACC;
          end else begin
            state_d = RD_ACC;
            mem_r_d = 1'b1;
          end
        end
      end
      WR_ACC: begin
        if (wr_valid) begin
          mem_w_d = 1'b1;
          mem_d_d = wr_data;
          state_d = WR_BEAT;
        end
      end
`ifdef RAM8_SEQ_WR_VERIFY_EN
      WR_BEAT: begin
        mem_r_d = 1'b1;
        state_d = VERIFY;
      end
      VERIFY: begin
        if (mem_q != mem_d_q) begin
          wr_err_d = 1'b1;
        end
        if (last) begin
          state_d = IDLE;
        end else begin
          ctr_inc = 1'b1;
          state_d = WR_ACC;
        end
      end
`else
      WR_BEAT: begin
        if (last) begin
          state_d = IDLE;
        end else begin
          ctr_inc = 1'b1;
          state_d = WR_ACC;
        end
      end
`endif
      RD_ACC: begin
        rd_data_d  = mem_q;
        rd_valid_d = 1'b1;
        state_d    = RD_HOLD;
      end
      RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (last) begin
            state_d = IDLE;
          end else begin
            ctr_inc = 1'b1;
            mem_r_d = 1'b1;
            state_d = RD_ACC;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (mem_r_d || mem_w_d) begin
      mem_addr_d = nxt_addr;
    end

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      mem_r_q     <= 1'b0;
      mem_w_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_d_q     <= '0;
`ifdef RAM8_SEQ_WR_VERIFY_EN
      wr_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      mem_r_q     <= mem_r_d;
      mem_w_q     <= mem_w_d;
      mem_addr_q  <= mem_addr_d;
      mem_d_q     <= mem_d_d;
`ifdef RAM8_SEQ_WR_VERIFY_EN
      wr_err_q    <= wr_err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = (state_q == WR_ACC);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign mem_r     = mem_r_q;
  assign mem_w     = mem_w_q;
  assign mem_addr  = mem_addr_q;
  assign mem_d     = mem_d_q;
`ifdef RAM8_SEQ_WR_VERIFY_EN
  assign wr_err    = wr_err_q;
`endif

endmodule

// File: tb/tb_ram8_seq_master.sv
// Directed self-checking bench for ram8_seq_master with a behavioural 8x16 RAM
// and scoreboard queues for expected writes, read addresses and read data.
module tb_ram8_seq_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_addr = '0;
  logic [2:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic        busy;
  logic        mem_r;
  logic        mem_w;
  logic [2:0]  mem_addr;
  logic [15:0] mem_d;
  logic [15:0] mem_q;
`ifdef RAM8_SEQ_WR_VERIFY_EN
  logic        wr_err;
`endif

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_exp_t;

  logic [15:0] ram [8];
  logic [15:0] model_mem [8];
  logic        force_zero = 1'b0;
  logic        tb_reading = 1'b0;
  logic [2:0]  wr_addr = '0;
  wr_exp_t     exp_wr_q [$];
  logic [2:0]  exp_rd_addr_q [$];
  logic [15:0] exp_rd_data_q [$];
  int          checks = 0;
  int          errors = 0;
  int          wr_pulses = 0;
  int          rd_pulses = 0;

  ram8_seq_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_addr  (mem_addr),
    .mem_d     (mem_d),
`ifdef RAM8_SEQ_WR_VERIFY_EN
    .wr_err    (wr_err),
`endif
    .mem_q     (mem_q)
  );

  always #5 clk = ~clk;

  // Register-file RAM: asynchronous read, write on the rising edge.
  assign mem_q = force_zero ? 16'h0000 : ram[mem_addr];
  always @(posedge clk) begin
    if (mem_w) ram[mem_addr] <= mem_d;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling edge where everything is settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_w || mem_r) checkOutput("strobe_excl", {31'd0, mem_w & mem_r}, 32'd0);
      if (mem_w) begin
        wr_exp_t e;
        wr_pulses++;
        checkOutput("wr_expected_avail", {31'd0, exp_wr_q.size() != 0}, 32'd1);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          checkOutput("wr_addr", {29'd0, mem_addr}, {29'd0, e.a});
          checkOutput("wr_data", {16'd0, mem_d}, {16'd0, e.d});
        end
      end
      if (mem_r && tb_reading) begin
        rd_pulses++;
        checkOutput("rd_expected_avail", {31'd0, exp_rd_addr_q.size() != 0}, 32'd1);
        if (exp_rd_addr_q.size() != 0)
          checkOutput("rd_addr", {29'd0, mem_addr}, {29'd0, exp_rd_addr_q.pop_front()});
      end
      if (rd_valid && rd_ready) begin
        checkOutput("rd_data_avail", {31'd0, exp_rd_data_q.size() != 0}, 32'd1);
        if (exp_rd_data_q.size() != 0)
          checkOutput("rd_data", {16'd0, rd_data}, {16'd0, exp_rd_data_q.pop_front()});
      end
    end
  end

  // Issue one command; read commands push their expected addresses and data.
  task automatic applyStimulus(input logic w, input logic [2:0] a, input logic [2:0] l);
    int n = 0;
    logic [2:0] ad;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    if (w) begin
      wr_addr = a;
    end else begin
      tb_reading = 1'b1;
      ad = a;
      for (int i = 0; i <= int'(l); i++) begin
        exp_rd_addr_q.push_back(ad);
        exp_rd_data_q.push_back(model_mem[ad]);
        ad = ad + 3'd1;
      end
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("accept_busy", {31'd0, busy}, 32'd1);
    checkOutput("accept_cmd_ready", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic sendBeat(input logic [15:0] d, input int gap, input logic last_beat);
    int n = 0;
    wr_exp_t e;
    while (!wr_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("wr_ready_wait", {31'd0, wr_ready}, 32'd1);
    e.a = wr_addr;
    e.d = d;
    exp_wr_q.push_back(e);
    model_mem[wr_addr] = d;
    wr_addr = wr_addr + 3'd1;
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    checkOutput("wr_latency_mem_w", {31'd0, mem_w}, 32'd1);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      checkOutput("gap_no_mem_w", {31'd0, mem_w}, 32'd0);
      if (!last_beat) checkOutput("gap_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
  endtask

  task automatic takeBeats(input int nbeats, input int stall);
    for (int b = 0; b < nbeats; b++) begin
      int n = 0;
      while (!rd_valid && n < 50) begin
        @(posedge clk); #1; n++;
      end
      checkOutput("rd_valid_wait", {31'd0, rd_valid}, 32'd1);
      for (int s = 0; s < stall; s++) begin
        checkOutput("stall_rd_valid", {31'd0, rd_valid}, 32'd1);
        checkOutput("stall_rd_data", {16'd0, rd_data}, {16'd0, exp_rd_data_q[0]});
        @(posedge clk); #1;
      end
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("wait_idle", {31'd0, busy}, 32'd0);
    tb_reading = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses0;
    for (int i = 0; i < 8; i++) begin
      ram[i]       = 16'h0100 + 16'(i);
      model_mem[i] = 16'h0100 + 16'(i);
    end

    // Reset values while rst is still asserted.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mem_r", {31'd0, mem_r}, 32'd0);
    checkOutput("rst_mem_w", {31'd0, mem_w}, 32'd0);
    checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rst_rd_data", {16'd0, rd_data}, 32'd0);
    checkOutput("rst_mem_addr", {29'd0, mem_addr}, 32'd0);
    checkOutput("rst_mem_d", {16'd0, mem_d}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("post_rst_wr_ready", {31'd0, wr_ready}, 32'd0);

    // Single-beat write then single-beat read at address 3.
    pulses0 = wr_pulses;
    applyStimulus(1'b1, 3'd3, 3'd0);
    sendBeat(16'd64, 0, 1'b1);
    waitIdle();
    checkOutput("single_write_pulses", wr_pulses - pulses0, 32'd1);
    applyStimulus(1'b0, 3'd3, 3'd0);
    checkOutput("rd_lat_c1_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rd_lat_c1_mem_r", {31'd0, mem_r}, 32'd1);
    checkOutput("rd_lat_c1_addr", {29'd0, mem_addr}, 32'd3);
    @(posedge clk); #1;
    checkOutput("rd_lat_c2_valid", {31'd0, rd_valid}, 32'd1);
    checkOutput("rd_lat_c2_data", {16'd0, rd_data}, 32'd64);
    checkOutput("rd_lat_c2_mem_r", {31'd0, mem_r}, 32'd0);
    takeBeats(1, 0);
    waitIdle();

    // Wrapping write burst 6,7,0,1 and read back.
    applyStimulus(1'b1, 3'd6, 3'd3);
    sendBeat(16'd78, 0, 1'b0);
    sendBeat(16'd79, 0, 1'b0);
    sendBeat(16'd80, 0, 1'b0);
    sendBeat(16'd81, 0, 1'b1);
    waitIdle();
    applyStimulus(1'b0, 3'd6, 3'd3);
    takeBeats(4, 0);
    waitIdle();

    // Full-depth read from 5 with the host stalling 4 cycles per beat.
    rd_pulses = 0;
    applyStimulus(1'b0, 3'd5, 3'd7);
    takeBeats(8, 4);
    waitIdle();
    checkOutput("stall_mem_r_pulses", rd_pulses, 32'd8);

    // Gapped write data, then read back.
    applyStimulus(1'b1, 3'd1, 3'd2);
    sendBeat(16'hA5A5, 2, 1'b0);
    sendBeat(16'h5A5A, 2, 1'b0);
    sendBeat(16'h1234, 2, 1'b1);
    waitIdle();
    applyStimulus(1'b0, 3'd1, 3'd2);
    takeBeats(3, 1);
    waitIdle();

    // Reset during the second beat of a read burst.
    applyStimulus(1'b0, 3'd3, 3'd5);
    takeBeats(1, 0);
    checkOutput("mid_rst_second_mem_r", {31'd0, mem_r}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_rst_mem_r", {31'd0, mem_r}, 32'd0);
    checkOutput("mid_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    exp_rd_addr_q.delete();
    exp_rd_data_q.delete();
    tb_reading = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("mid_rst_no_strobe", {30'd0, mem_r, mem_w}, 32'd0);
    end

`ifdef RAM8_SEQ_WR_VERIFY_EN
    // Read-back mismatch must set the sticky error flag.
    checkOutput("verify_no_false_err", {31'd0, wr_err}, 32'd0);
    force_zero = 1'b1;
    applyStimulus(1'b1, 3'd2, 3'd0);
    sendBeat(16'd5, 0, 1'b1);
    waitIdle();
    force_zero = 1'b0;
    checkOutput("verify_err_set", {31'd0, wr_err}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("verify_err_sticky", {31'd0, wr_err}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("verify_err_cleared", {31'd0, wr_err}, 32'd0);
    @(posedge clk); #1;
`endif

    checkOutput("wr_queue_drained", exp_wr_q.size(), 32'd0);
    checkOutput("rd_queue_drained", exp_rd_data_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
